// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - shares the memory request port between ICache fill and DCache MSHRs
// Optional build macro: MEM_ACCESS_ARB_ICACHE_PRIORITY_EN (ICache wins ties instead of round-robin).
module mem_access_arbiter #(
  parameter int READ_SERIAL_NUM  = 3,
  parameter int WRITE_SERIAL_NUM = 2,
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32,
  localparam int SER_W  = (READ_SERIAL_NUM  > 1) ? $clog2(READ_SERIAL_NUM)  : 1,
  localparam int WSER_W = (WRITE_SERIAL_NUM > 1) ? $clog2(WRITE_SERIAL_NUM) : 1,
  localparam int WCNT_W = $clog2(WRITE_SERIAL_NUM + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ic_req_valid,
  input  logic [ADDR_W-1:0] i_ic_req_addr,
  output logic              o_ic_ack,
  output logic [SER_W-1:0]  o_ic_ack_serial,
  output logic [WSER_W-1:0] o_ic_ack_wserial,
  input  logic              i_dc_req_valid,
  input  logic              i_dc_req_we,
  input  logic [ADDR_W-1:0] i_dc_req_addr,
  input  logic [DATA_W-1:0] i_dc_req_wdata,
  output logic              o_dc_ack,
  output logic [SER_W-1:0]  o_dc_ack_serial,
  output logic [WSER_W-1:0] o_dc_ack_wserial,
  output logic              o_mem_req_valid,
  output logic              o_mem_req_we,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  output logic [DATA_W-1:0] o_mem_req_wdata,
  output logic [SER_W-1:0]  o_mem_req_serial,
  output logic [WSER_W-1:0] o_mem_req_wserial,
  input  logic              i_mem_req_ready,
  input  logic              i_mem_rd_valid,
  input  logic [SER_W-1:0]  i_mem_rd_serial,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  input  logic              i_mem_wr_resp_valid,
  input  logic [WSER_W-1:0] i_mem_wr_resp_wserial,
  output logic              o_ic_rd_valid,
  output logic [SER_W-1:0]  o_ic_rd_serial,
  output logic [DATA_W-1:0] o_ic_rd_data,
  output logic              o_dc_rd_valid,
  output logic [SER_W-1:0]  o_dc_rd_serial,
  output logic [DATA_W-1:0] o_dc_rd_data,
  output logic              o_dc_wr_resp_valid,
  output logic [WSER_W-1:0] o_dc_wr_resp_wserial,
  output logic              o_protocol_error
);

  logic [READ_SERIAL_NUM-1:0] r_free_vec;
  logic [READ_SERIAL_NUM-1:0] r_owner;
  logic [WCNT_W-1:0]          r_wr_count;
  logic [WSER_W-1:0]          r_wr_ptr;
  logic                       r_err;
  logic                       r_mem_valid;
  logic                       r_mem_we;
  logic [ADDR_W-1:0]          r_mem_addr;
  logic [DATA_W-1:0]          r_mem_wdata;
  logic [SER_W-1:0]           r_mem_serial;
  logic [WSER_W-1:0]          r_mem_wserial;
`ifndef MEM_ACCESS_ARB_ICACHE_PRIORITY_EN
  logic                       r_rr_dc;
`endif

  logic [(2**SER_W)-1:0] w_free_pad;
  logic [(2**SER_W)-1:0] w_owner_pad;
  logic [SER_W-1:0]      w_alloc_idx;
  logic                  w_rd_avail;
  logic                  w_wr_avail;
  logic                  w_oreg_free;
  logic                  w_ic_elig;
  logic                  w_dc_elig;
  logic                  w_grant_ic;
  logic                  w_grant_dc;
  logic                  w_grant_rd;
  logic                  w_grant_wr;
  logic                  w_rd_hit;
  logic                  w_wr_hit;

  // Serial indices beyond READ_SERIAL_NUM read as free, so a stray result flags an error.
  always_comb begin
    w_free_pad  = '1;
    w_owner_pad = '0;
    w_free_pad[READ_SERIAL_NUM-1:0]  = r_free_vec;
    w_owner_pad[READ_SERIAL_NUM-1:0] = r_owner;
  end

  always_comb begin
    w_alloc_idx = '0;
    w_rd_avail  = 1'b0;
    for (int i = READ_SERIAL_NUM - 1; i >= 0; i--) begin
      if (r_free_vec[i]) begin
        w_alloc_idx = SER_W'(i);
        w_rd_avail  = 1'b1;
      end
    end
  end

  assign w_wr_avail  = (r_wr_count < WCNT_W'(WRITE_SERIAL_NUM));
  assign w_oreg_free = !r_mem_valid || i_mem_req_ready;
  assign w_ic_elig   = i_ic_req_valid && w_rd_avail;
  assign w_dc_elig   = i_dc_req_valid && (i_dc_req_we ? w_wr_avail : w_rd_avail);

  always_comb begin
    w_grant_ic = 1'b0;
    w_grant_dc = 1'b0;
    if (i_rst_n && w_oreg_free) begin
`ifdef MEM_ACCESS_ARB_ICACHE_PRIORITY_EN
      if (w_ic_elig)      w_grant_ic = 1'b1;
      else if (w_dc_elig) w_grant_dc = 1'b1;
`else
      if (w_ic_elig && (!r_rr_dc || !w_dc_elig)) w_grant_ic = 1'b1;
      else if (w_dc_elig)                        w_grant_dc = 1'b1;
`endif
    end
  end

  assign w_grant_rd = w_grant_ic || (w_grant_dc && !i_dc_req_we);
  assign w_grant_wr = w_grant_dc && i_dc_req_we;
  assign w_rd_hit   = i_mem_rd_valid && !w_free_pad[i_mem_rd_serial];
  assign w_wr_hit   = i_mem_wr_resp_valid && (r_wr_count != '0);

  assign o_ic_ack         = w_grant_ic;
  assign o_ic_ack_serial  = w_grant_ic ? w_alloc_idx : '0;
  assign o_ic_ack_wserial = '0;
  assign o_dc_ack         = w_grant_dc;
  assign o_dc_ack_serial  = (w_grant_dc && !i_dc_req_we) ? w_alloc_idx : '0;
  assign o_dc_ack_wserial = w_grant_wr ? r_wr_ptr : '0;

  assign o_ic_rd_valid        = w_rd_hit && w_owner_pad[i_mem_rd_serial];
  assign o_ic_rd_serial       = o_ic_rd_valid ? i_mem_rd_serial : '0;
  assign o_ic_rd_data         = o_ic_rd_valid ? i_mem_rd_data : '0;
  assign o_dc_rd_valid        = w_rd_hit && !w_owner_pad[i_mem_rd_serial];
  assign o_dc_rd_serial       = o_dc_rd_valid ? i_mem_rd_serial : '0;
  assign o_dc_rd_data         = o_dc_rd_valid ? i_mem_rd_data : '0;
  assign o_dc_wr_resp_valid   = w_wr_hit;
  assign o_dc_wr_resp_wserial = w_wr_hit ? i_mem_wr_resp_wserial : '0;

  assign o_mem_req_valid   = r_mem_valid;
  assign o_mem_req_we      = r_mem_we;
  assign o_mem_req_addr    = r_mem_addr;
  assign o_mem_req_wdata   = r_mem_wdata;
  assign o_mem_req_serial  = r_mem_serial;
  assign o_mem_req_wserial = r_mem_wserial;
  assign o_protocol_error  = r_err;

  // A serial released this cycle is only visible to allocation from the next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_free_vec <= '1;
      r_owner    <= '0;
    end else begin
      for (int i = 0; i < READ_SERIAL_NUM; i++) begin
        if (w_rd_hit && i_mem_rd_serial == SER_W'(i)) r_free_vec[i] <= 1'b1;
        if (w_grant_rd && w_alloc_idx == SER_W'(i)) begin
          r_free_vec[i] <= 1'b0;
          r_owner[i]    <= w_grant_ic;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_count <= '0;
      r_wr_ptr   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_grant_wr && !w_wr_hit)      r_wr_count <= r_wr_count + 1'b1;
      else if (!w_grant_wr && w_wr_hit) r_wr_count <= r_wr_count - 1'b1;
      if (w_grant_wr)
        r_wr_ptr <= (r_wr_ptr == WSER_W'(WRITE_SERIAL_NUM - 1)) ? '0 : r_wr_ptr + 1'b1;
      if ((i_mem_rd_valid && !w_rd_hit) || (i_mem_wr_resp_valid && !w_wr_hit))
        r_err <= 1'b1;
    end
  end

`ifndef MEM_ACCESS_ARB_ICACHE_PRIORITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      r_rr_dc <= 1'b0;
    else if (w_grant_ic || w_grant_dc) r_rr_dc <= w_grant_ic;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_valid   <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_serial  <= '0;
      r_mem_wserial <= '0;
    end else if (w_grant_ic || w_grant_dc) begin
      r_mem_valid   <= 1'b1;
      r_mem_we      <= w_grant_wr;
      r_mem_addr    <= w_grant_ic ? i_ic_req_addr : i_dc_req_addr;
      r_mem_wdata   <= w_grant_dc ? i_dc_req_wdata : '0;
      r_mem_serial  <= w_grant_rd ? w_alloc_idx : '0;
      r_mem_wserial <= w_grant_wr ? r_wr_ptr : '0;
    end else if (i_mem_req_ready) begin
      r_mem_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

- Shares the single main-memory request port between the ICache line-fill path and the DCache MSHRs.
- Allocates read serials (MemAccessSerial) and write serials (MemWriteSerial), and tracks outstanding transactions.
- Holds one registered request towards memory.
- Routes read results and write responses back to the requester that owns each serial.
- Sits between the cache subsystem and the memory/AXI bridge.

## Interface
Parameters:
- READ_SERIAL_NUM, default MSHR_NUM+1 (3): read serials that can be outstanding at once.
- WRITE_SERIAL_NUM, default MSHR_NUM (2): write serials that can be outstanding at once.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- icReq  in  MemReadAccessReq  ICache read request; held stable until acked.
- icReqAck  out  MemAccessReqAck  ack plus assigned read serial; wserial = 0.
- dcReq  in  MemAccessReq  DCache read (we=0) or write (we=1) request; held until acked.
- dcReqAck  out  MemAccessReqAck  ack plus assigned serial (reads) or wserial (writes).
- memReq  out  MemAccessReq  registered request to memory.
- memReqSerial  out  MemAccessSerial  serial of memReq.
- memReqWSerial  out  MemWriteSerial  write serial of memReq.
- memReqReady  in  1  memory accepts memReq this cycle.
- memReadResult  in  MemAccessResult  read data returned from memory, tagged with serial.
- memWriteResp  in  MemAccessResponse  write completion returned from memory.
- icReadResult  out  MemAccessResult  read result routed to the ICache.
- dcReadResult  out  MemAccessResult  read result routed to the DCache.
- dcWriteResp  out  MemAccessResponse  write completion routed to the DCache.
- protocolError  out  1  sticky error flag.

## Operation
- Output register (OREG) is one entry. It is "free" when invalid, or when valid with memReqReady=1 in the current cycle.
- Eligibility:
  - ICache request: icReq.valid and a read serial is free.
  - DCache read: dcReq.valid and a read serial is free.
  - DCache write: dcReq.valid and wrCount < WRITE_SERIAL_NUM.
- Grant:
  - At most one grant per cycle, only when OREG is free.
  - Round-robin between the two requesters. The priority pointer flips to the other requester after every grant.
  - A non-eligible requester never blocks an eligible one.
- Ack:
  - The granted requester's ack.ack=1 is combinational in the same cycle.
  - The serial (or wserial) is valid with the ack.
  - The request is copied into OREG at the next edge.
- Read serial allocation:
  - Take the lowest-index free bit of freeVec[READ_SERIAL_NUM].
  - Record the owner bit (1 = ICache).
- Write serial allocation:
  - wserial = wrPtr; wrPtr increments modulo WRITE_SERIAL_NUM.
  - wrCount increments.
- Read result routing (memReadResult.valid): forward to icReadResult or dcReadResult according to owner[serial]; the other output has valid=0. Set freeVec[serial].
- Write response (memWriteResp.valid): forward to dcWriteResp and decrement wrCount.
- Error cases:
  - A read result whose serial is already free is dropped and sets protocolError.
  - A write response with wrCount=0 is dropped and sets protocolError.
  - protocolError is cleared only by reset.

## Timing
- Request path: ack and grant in cycle N; memReq.valid in N+1. Minimum 1 cycle from request to memory.
- OREG holds its value until memReqReady=1. With memReqReady held high, back-to-back grants give one request per cycle.
- Result and response routing: combinational, 0 cycles.
- Serial state updates on the edge after the event.
- A serial freed in cycle N is allocatable from N+1, never in N.
- Simultaneous write grant and write response: wrCount unchanged.
- Reset (asynchronous, any time) forces:
  - all freeVec bits = 1, owner = 0, wrCount = 0, wrPtr = 0;
  - OREG invalid (memReq = 0, memReqSerial = 0, memReqWSerial = 0);
  - RR pointer set to ICache first;
  - protocolError = 0;
  - all ack outputs 0.
- In-flight transactions are forgotten at reset. Memory must be reset together with this block.

## Configuration
- MEM_ACCESS_ARB_ICACHE_PRIORITY_EN:
  - Defined: the ICache always wins when both requesters are eligible, and the RR pointer is unused. This minimises fetch stall.
  - Undefined: round-robin as described above.

## Test plan
- Reset, then icReq addr 0x100 alone, memReqReady=1 → icReqAck.ack=1 with serial 0 in cycle N; memReq {valid=1, we=0, addr=0x100} with serial 0 in N+1.
- icReq and dcReq read both valid every cycle, memReqReady=1 → grants alternate IC, DC, IC (serials 0, 1, 2); fourth cycle no ack until a result returns.
- Three reads outstanding; memReadResult serial 1 returns in cycle N → routed to dcReadResult only; the next pending request gets serial 1 in N+1, not in N.
- Two DCache writes acked (wserials 0, 1); third write stalls; memWriteResp serial 0 → dcWriteResp.valid=1, then the third write acked with wserial 0.
- memReqReady=0 for 5 cycles with a request in OREG → memReq stable, no new acks; memReqReady=1 → new ack in the same cycle.
- memReadResult with a free serial 2 → dropped, protocolError=1 until rst=0; then all outputs at reset values.
